// File: rtl/thread_sched.sv
// Four-thread fetch scheduler: per-thread RUN/WAIT/HALT FSM, per-thread PC,
// and a round-robin arbiter that issues one registered fetch slot per cycle.
module thread_sched #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      thread_en_i,
    input  logic [3:0]      stall_i,
    input  logic            ifu_ready_i,
    input  logic            redirect_valid_i,
    input  logic [1:0]      redirect_thread_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [1:0]      trap_thread_i,
    output logic            fetch_valid_o,
    output logic [1:0]      thread_id_o,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic [7:0]      thread_state_o,
    output logic            all_halted_o
);
    localparam int NT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10,
        HALT = 2'b11
    } state_e;

    state_e                     state_q [NT];
    state_e                     state_d [NT];
    logic [NT-1:0][XLEN-1:0]    pc_q, pc_d;
    logic [1:0]                 last_grant_q, last_grant_d;
    logic                       fetch_valid_q, fetch_valid_d;
    logic [1:0]                 thread_id_q, thread_id_d;
    logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d;

    logic [NT-1:0]              redir_hit, trap_hit, elig;
    logic                       any_elig;
    logic [1:0]                 winner, cand;
    logic                       squash, load;
    logic [XLEN-1:0]            redir_pc_aligned;

    assign redir_pc_aligned = redirect_pc_i & ~XLEN'(3);

    always_comb begin
        redir_hit = '0;
        trap_hit  = '0;
        elig      = '0;
        for (int t = 0; t < NT; t++) begin
            redir_hit[t] = redirect_valid_i && (redirect_thread_i == 2'(t));
            trap_hit[t]  = trap_valid_i && (trap_thread_i == 2'(t));
            elig[t]      = (state_q[t] == RUN) && !stall_i[t] && !redir_hit[t] && !trap_hit[t];
        end
    end

    // Round-robin: first eligible thread after the last grant, wrapping mod 4.
    always_comb begin
        any_elig = 1'b0;
        winner   = last_grant_q;
        cand     = last_grant_q;
        for (int k = 1; k <= NT; k++) begin
            cand = last_grant_q + 2'(k);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    // A redirect or trap aimed at the thread owning the current slot kills it,
    // which also frees the output register even when the fetch unit is stalled.
    assign squash = fetch_valid_q &&
                    ((redirect_valid_i && (redirect_thread_i == thread_id_q)) ||
                     (trap_valid_i && (trap_thread_i == thread_id_q)));
    assign load   = !fetch_valid_q || ifu_ready_i || squash;

    always_comb begin
        last_grant_d  = last_grant_q;
        fetch_valid_d = fetch_valid_q;
        thread_id_d   = thread_id_q;
        fetch_pc_d    = fetch_pc_q;
        if (load) begin
            fetch_valid_d = any_elig;
            if (any_elig) begin
                thread_id_d  = winner;
                fetch_pc_d   = pc_q[winner];
                last_grant_d = winner;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            state_d[t] = state_q[t];
            pc_d[t]    = pc_q[t];
            if (!thread_en_i[t]) begin
                state_d[t] = IDLE;
            end else begin
                case (state_q[t])
                    IDLE: begin
                        state_d[t] = RUN;
                        pc_d[t]    = RESET_PC;
                    end
                    RUN: begin
                        if (trap_hit[t])     state_d[t] = HALT;
                        else if (stall_i[t]) state_d[t] = WAIT;
                    end
                    WAIT: begin
                        if (trap_hit[t])      state_d[t] = HALT;
                        else if (!stall_i[t]) state_d[t] = RUN;
                    end
                    default: state_d[t] = HALT;
                endcase
            end
            if (load && any_elig && (winner == 2'(t)))
                pc_d[t] = pc_q[t] + XLEN'(4);
            // Redirect wins over everything, including a same-cycle trap.
            if (redir_hit[t])
                pc_d[t] = redir_pc_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NT; t++) begin
                state_q[t] <= IDLE;
                pc_q[t]    <= RESET_PC;
            end
            last_grant_q  <= 2'd3;
            fetch_valid_q <= 1'b0;
            thread_id_q   <= 2'd0;
            fetch_pc_q    <= RESET_PC;
        end else begin
            for (int t = 0; t < NT; t++) begin
                state_q[t] <= state_d[t];
                pc_q[t]    <= pc_d[t];
            end
            last_grant_q  <= last_grant_d;
            fetch_valid_q <= fetch_valid_d;
            thread_id_q   <= thread_id_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

    always_comb begin
        thread_state_o = '0;
        all_halted_o   = 1'b1;
        for (int t = 0; t < NT; t++) begin
            thread_state_o[2*t +: 2] = state_q[t];
            if ((state_q[t] == RUN) || (state_q[t] == WAIT))
                all_halted_o = 1'b0;
        end
    end

    assign fetch_valid_o = fetch_valid_q;
    assign thread_id_o   = thread_id_q;
    assign fetch_pc_o    = fetch_pc_q;

endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched: hand-computed expectations checked with
// immediate assertions one cycle at a time.
module tb_thread_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  thread_en_i;
    logic [3:0]  stall_i;
    logic        ifu_ready_i;
    logic        redirect_valid_i;
    logic [1:0]  redirect_thread_i;
    logic [31:0] redirect_pc_i;
    logic        trap_valid_i;
    logic [1:0]  trap_thread_i;
    logic        fetch_valid_o;
    logic [1:0]  thread_id_o;
    logic [31:0] fetch_pc_o;
    logic [7:0]  thread_state_o;
    logic        all_halted_o;

    int errors = 0;
    int checks = 0;

    thread_sched #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .thread_en_i       (thread_en_i),
        .stall_i           (stall_i),
        .ifu_ready_i       (ifu_ready_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_thread_i (redirect_thread_i),
        .redirect_pc_i     (redirect_pc_i),
        .trap_valid_i      (trap_valid_i),
        .trap_thread_i     (trap_thread_i),
        .fetch_valid_o     (fetch_valid_o),
        .thread_id_o       (thread_id_o),
        .fetch_pc_o        (fetch_pc_o),
        .thread_state_o    (thread_state_o),
        .all_halted_o      (all_halted_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input logic [1:0] id, input logic [31:0] pc);
        chk({tag, ".valid"}, 64'(fetch_valid_o), 64'd1);
        chk({tag, ".id"},    64'(thread_id_o),   64'(id));
        chk({tag, ".pc"},    64'(fetch_pc_o),    64'(pc));
    endtask

    task automatic do_reset(input logic [3:0] en);
        rst = 1'b1; thread_en_i = en; stall_i = '0; ifu_ready_i = 1'b1;
        redirect_valid_i = 1'b0; redirect_thread_i = '0; redirect_pc_i = '0;
        trap_valid_i = 1'b0; trap_thread_i = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset(4'b0000);
        step();
        do_reset(4'b0000);
        chk("rst.valid",  64'(fetch_valid_o),  64'd0);
        chk("rst.id",     64'(thread_id_o),    64'd0);
        chk("rst.pc",     64'(fetch_pc_o),     64'd0);
        chk("rst.state",  64'(thread_state_o), 64'h00);
        chk("rst.halted", 64'(all_halted_o),   64'd1);

        // Four running threads share slots in strict rotation
        thread_en_i = 4'b1111;
        step();
        chk("rr.state",  64'(thread_state_o), 64'h55);
        chk("rr.halted", 64'(all_halted_o),   64'd0);
        chk("rr.valid0", 64'(fetch_valid_o),  64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            slot($sformatf("rr%0d", i), 2'(i % 4), 32'((i / 4) * 4));
        end

        // Thread 2 stalls for three cycles, thread 0 keeps issuing
        do_reset(4'b0101);
        step();
        step(); slot("st.a", 2'd0, 32'h0);
        step(); slot("st.b", 2'd2, 32'h0);
        step(); slot("st.c", 2'd0, 32'h4);
        stall_i = 4'b0100;
        step(); slot("st.d", 2'd0, 32'h8);
        chk("st.wait", 64'(thread_state_o), 64'h21);
        step(); slot("st.e", 2'd0, 32'hC);
        step(); slot("st.f", 2'd0, 32'h10);
        stall_i = 4'b0000;
        step(); slot("st.g", 2'd0, 32'h14);
        chk("st.run", 64'(thread_state_o), 64'h11);
        step(); slot("st.h", 2'd2, 32'h4);

        // Backpressure freezes the slot; a redirect squashes it
        do_reset(4'b0010);
        step();
        step(); slot("bp.a", 2'd1, 32'h0);
        ifu_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            slot($sformatf("bp.hold%0d", i), 2'd1, 32'h0);
        end
        redirect_valid_i = 1'b1; redirect_thread_i = 2'd1; redirect_pc_i = 32'h103;
        step();
        chk("bp.squash", 64'(fetch_valid_o), 64'd0);
        redirect_valid_i = 1'b0; ifu_ready_i = 1'b1;
        step(); slot("bp.redir", 2'd1, 32'h100);
        step(); slot("bp.next",  2'd1, 32'h104);

        // Trap halts thread 3; restart goes through IDLE back to RESET_PC
        do_reset(4'b1000);
        step();
        chk("tr.run", 64'(thread_state_o), 64'h40);
        step(); slot("tr.a", 2'd3, 32'h0);
        trap_valid_i = 1'b1; trap_thread_i = 2'd3;
        step();
        chk("tr.halt",   64'(thread_state_o), 64'hC0);
        chk("tr.squash", 64'(fetch_valid_o),  64'd0);
        chk("tr.allh",   64'(all_halted_o),   64'd1);
        trap_valid_i = 1'b0;
        step();
        chk("tr.stay", 64'(thread_state_o), 64'hC0);
        thread_en_i = 4'b0000;
        step();
        chk("tr.idle", 64'(thread_state_o), 64'h00);
        thread_en_i = 4'b1000;
        step();
        chk("tr.rerun", 64'(thread_state_o), 64'h40);
        step(); slot("tr.restart", 2'd3, 32'h0);

        // PC wraps at 2^32; redirect low bits are cleared
        do_reset(4'b0001);
        step();
        redirect_valid_i = 1'b1; redirect_thread_i = 2'd0; redirect_pc_i = 32'hFFFF_FFFE;
        step();
        chk("wr.noslot", 64'(fetch_valid_o), 64'd0);
        redirect_valid_i = 1'b0;
        step(); slot("wr.top",  2'd0, 32'hFFFF_FFFC);
        step(); slot("wr.wrap", 2'd0, 32'h0);

        // Redirect and trap to the same thread in one cycle: thread halts
        redirect_valid_i = 1'b1; redirect_thread_i = 2'd0; redirect_pc_i = 32'h200;
        trap_valid_i = 1'b1; trap_thread_i = 2'd0;
        step();
        chk("rt.halt",   64'(thread_state_o), 64'h03);
        chk("rt.squash", 64'(fetch_valid_o),  64'd0);
        redirect_valid_i = 1'b0; trap_valid_i = 1'b0;

        // Reset while a slot is held and a redirect is pending
        do_reset(4'b0001);
        step();
        step(); slot("mr.a", 2'd0, 32'h0);
        ifu_ready_i = 1'b0;
        redirect_valid_i = 1'b1; redirect_thread_i = 2'd2; redirect_pc_i = 32'h40;
        rst = 1'b1;
        step();
        chk("mr.valid",  64'(fetch_valid_o),  64'd0);
        chk("mr.state",  64'(thread_state_o), 64'h00);
        chk("mr.halted", 64'(all_halted_o),   64'd1);
        chk("mr.pc",     64'(fetch_pc_o),     64'd0);
        rst = 1'b0; redirect_valid_i = 1'b0; ifu_ready_i = 1'b1;
        step();
        chk("mr.run", 64'(thread_state_o), 64'h01);
        step(); slot("mr.resume", 2'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
